regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback sources:
//  - A: the in-order pipeline WB stage.
//  - B: a multi-cycle unit (MDU/load return).
//  Fixed priority to A, with a starvation guard that forces a B grant.
//  Registered outputs drive the register file write port (addr/data/enable).
//  Sits between the WB stage / multi-cycle unit and the register file.
// PARAMETERS
//  REG_NUM_BITWIDTH  5   register index width
//  WORD_BITWIDTH     32  write data width
//  STARVE_LIMIT      4   consecutive cycles B may wait before a forced grant (>=1)
//  CNT_BITWIDTH      3   width of wait counter; must hold STARVE_LIMIT
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    reset, asynchronous, active-high
//  a_valid     in   1    source A has a write pending
//  a_rd        in   RNB  source A destination register
//  a_data      in   WB   source A write data
//  a_ready     out  1    A handshake accepted this cycle (combinational)
//  b_valid     in   1    source B has a write pending
//  b_rd        in   RNB  source B destination register
//  b_data      in   WB   source B write data
//  b_ready     out  1    B handshake accepted this cycle (combinational)
//  rf_wr_en    out  1    register-file write enable (registered)
//  rf_wr_addr  out  RNB  register-file write index (registered)
//  rf_wr_data  out  WB   register-file write data (registered)
//  b_forced    out  1    current B grant is a starvation-forced grant (combinational)
// BEHAVIOUR
//  Reset (async): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, wait_cnt=0.
//  - a_ready and b_ready are 0 while rst is high.
//  Grant (combinational, evaluated each cycle):
//  - force = b_valid && (wait_cnt == STARVE_LIMIT).
//  - If force: grant B, even when a_valid=1.
//  - Else if a_valid: grant A.
//  - Else if b_valid: grant B.
//  - Else: no grant.
//  - a_ready = grant A; b_ready = grant B; never both high; b_forced = force.
//  Handshake:
//  - A transfer completes when valid && ready in the same cycle.
//  - Sources hold valid/rd/data stable until ready. Valid never depends on ready.
//  Write port, one cycle latency after the handshake edge:
//  - rf_wr_addr/rf_wr_data <= granted rd/data.
//  - rf_wr_en <= 1 if granted rd != 0, else 0.
//  - x0 writes complete the handshake but are dropped (rf_wr_en stays 0).
//  - No grant: rf_wr_en <= 0; addr/data hold their previous value.
//  wait_cnt:
//  - Cleared when B is granted or b_valid=0.
//  - Incremented when b_valid && !b_ready; saturates at STARVE_LIMIT.
//  - After a forced grant, wait_cnt=0, so A regains priority next cycle.
//  - Worst-case B latency is STARVE_LIMIT+1 cycles under continuous A traffic.
//  Simultaneous same rd from A and B: granted order defines the write order.
//  - Ordering correctness is the issuing logic's job; no merge or check here.
//  Reset mid-operation:
//  - Any in-flight registered write is cancelled (rf_wr_en=0).
//  - wait_cnt clears; pending requests re-arbitrate after rst deasserts.
// TESTING
//  1 Reset: assert rst mid-write -> rf_wr_en=0, addr=0, data=0, a_ready=b_ready=0 immediately.
//  2 A only: a_valid=1, a_rd=5, a_data=0xDEADBEEF
//    -> a_ready=1 same cycle; next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF.
//  3 Starvation: a_valid held 1, b_valid=1 (b_rd=7) with STARVE_LIMIT=4
//    -> B waits 4 cycles; cycle 5 b_ready=1, b_forced=1, a_ready=0; next cycle A granted.
//  4 x0 drop: b_valid=1, b_rd=0, b_data=0x1234
//    -> b_ready=1; next cycle rf_wr_en=0.
//  5 Both valid, counter low: a_rd=3, b_rd=3
//    -> A written first (addr=3, A data); B granted next cycle; final write carries B data.
//  6 Idle gap: all valids 0 after a write
//    -> rf_wr_en drops to 0 the next cycle; addr/data hold; wait_cnt stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB stage (A)
// and a multi-cycle unit (B): A has priority, and a wait counter forces a B grant.
module regfile_wb_arbiter #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32,
  parameter int STARVE_LIMIT     = 4,
  parameter int CNT_BITWIDTH     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] a_rd,
  input  logic [WORD_BITWIDTH-1:0]    a_data,
  output logic                        a_ready,
  input  logic                        b_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] b_rd,
  input  logic [WORD_BITWIDTH-1:0]    b_data,
  output logic                        b_ready,
  output logic                        rf_wr_en,
  output logic [REG_NUM_BITWIDTH-1:0] rf_wr_addr,
  output logic [WORD_BITWIDTH-1:0]    rf_wr_data,
  output logic                        b_forced
);

  localparam logic [CNT_BITWIDTH-1:0]     LIMIT = CNT_BITWIDTH'(STARVE_LIMIT);
  localparam logic [REG_NUM_BITWIDTH-1:0] X0    = {REG_NUM_BITWIDTH{1'b0}};

  logic [CNT_BITWIDTH-1:0] wait_cnt_r;
  logic                    grant_a_s;
  logic                    grant_b_s;
  logic                    force_s;

  // Grant decision; a starved B overrides A, and nothing is granted while in reset.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    force_s   = 1'b0;
    if (rst) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else begin
      force_s = b_valid && (wait_cnt_r == LIMIT);
      if (force_s) begin
        grant_b_s = 1'b1;
      end else if (a_valid) begin
        grant_a_s = 1'b1;
      end else if (b_valid) begin
        grant_b_s = 1'b1;
      end else begin
        grant_b_s = 1'b0;
      end
    end
  end

  assign a_ready  = grant_a_s;
  assign b_ready  = grant_b_s;
  assign b_forced = force_s;

  // Registered write port; x0 writes are accepted but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= {REG_NUM_BITWIDTH{1'b0}};
      rf_wr_data <= {WORD_BITWIDTH{1'b0}};
    end else if (grant_a_s) begin
      rf_wr_en   <= (a_rd != X0);
      rf_wr_addr <= a_rd;
      rf_wr_data <= a_data;
    end else if (grant_b_s) begin
      rf_wr_en   <= (b_rd != X0);
      rf_wr_addr <= b_rd;
      rf_wr_data <= b_data;
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

  // Counts consecutive cycles B has been refused, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {CNT_BITWIDTH{1'b0}};
    end else if (!b_valid || grant_b_s) begin
      wait_cnt_r <= {CNT_BITWIDTH{1'b0}};
    end else if (wait_cnt_r != LIMIT) begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a request-level model predicts grants and
// register-file writes; a negedge monitor pops and compares the predictions.
module tb_regfile_wb_arbiter;
  localparam int RNB = 5;
  localparam int WB  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [RNB-1:0] a_rd, b_rd, rf_wr_addr;
  logic [WB-1:0] a_data, b_data, rf_wr_data;
  logic rf_wr_en, b_forced;

  regfile_wb_arbiter #(.REG_NUM_BITWIDTH(RNB), .WORD_BITWIDTH(WB), .STARVE_LIMIT(LIM),
                       .CNT_BITWIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .b_forced(b_forced)
  );

  always #5 clk = ~clk;

  typedef struct { logic en; logic [RNB-1:0] addr; logic [WB-1:0] data; } wr_t;
  typedef struct { logic ar; logic br; logic bf; } rdy_t;

  wr_t  rf_q[$];
  rdy_t rdy_q[$];
  wr_t  mon_w;
  rdy_t mon_r;
  wr_t  last_wr;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  // Pending requests of each source and how long B has been refused so far.
  bit           a_pend, b_pend;
  logic [RNB-1:0] a_rd_m, b_rd_m;
  logic [WB-1:0]  a_d_m, b_d_m;
  int           b_refused;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic req_a(input logic [RNB-1:0] rd, input logic [WB-1:0] d);
    a_pend = 1'b1; a_rd_m = rd; a_d_m = d;
  endtask

  task automatic req_b(input logic [RNB-1:0] rd, input logic [WB-1:0] d);
    b_pend = 1'b1; b_rd_m = rd; b_d_m = d;
  endtask

  // One cycle: drive pending requests, predict the grant and the write it produces.
  task automatic step();
    bit fz, ga, gb;
    wr_t nxt;
    @(posedge clk); #1;
    a_valid = a_pend; a_rd = a_rd_m; a_data = a_d_m;
    b_valid = b_pend; b_rd = b_rd_m; b_data = b_d_m;
    fz = b_pend && (b_refused >= LIM);
    ga = !fz && a_pend;
    gb = b_pend && !ga;
    rdy_q.push_back('{ga, gb, fz});
    if (ga)      nxt = '{a_rd_m != 0, a_rd_m, a_d_m};
    else if (gb) nxt = '{b_rd_m != 0, b_rd_m, b_d_m};
    else         nxt = '{1'b0, last_wr.addr, last_wr.data};
    rf_q.push_back(nxt);
    last_wr = nxt;
    if (gb || !b_pend) b_refused = 0;
    else b_refused++;
    if (ga) a_pend = 1'b0;
    if (gb) b_pend = 1'b0;
  endtask

  task automatic model_clear();
    a_pend = 1'b0; b_pend = 1'b0; b_refused = 0;
    a_rd_m = '0; b_rd_m = '0; a_d_m = '0; b_d_m = '0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
    rdy_q.delete(); rf_q.delete();
    last_wr = '{1'b0, '0, '0};
    rf_q.push_back(last_wr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(rf_wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(rf_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, rf_wr_data, 32'd0);
    chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
  endtask

  // Monitor: each cycle with an issued stimulus, compare handshakes and the write port.
  always @(negedge clk) begin
    if (mon_en && rdy_q.size() > 0) begin
      mon_r = rdy_q.pop_front();
      chk("a_ready", 32'(a_ready), 32'(mon_r.ar));
      chk("b_ready", 32'(b_ready), 32'(mon_r.br));
      chk("b_forced", 32'(b_forced), 32'(mon_r.bf));
      if (rf_q.size() == 0) begin
        n_chk++;
        $display("FAIL rf_queue: no expected write available (t=%0t)", $time);
      end else begin
        mon_w = rf_q.pop_front();
        chk("rf_wr_en", 32'(rf_wr_en), 32'(mon_w.en));
        chk("rf_wr_addr", 32'(rf_wr_addr), 32'(mon_w.addr));
        chk("rf_wr_data", rf_wr_data, mon_w.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    mon_en = 1'b1;

    // A only, then an idle gap that must drop the enable and hold addr/data.
    req_a(5'd5, 32'hDEAD_BEEF);
    step();
    step();
    step();

    // Starvation: A continuously valid while B (x7) waits for a forced grant.
    req_b(5'd7, 32'h0B0B_0007);
    for (int i = 0; i < 8; i++) begin
      if (!a_pend) req_a(5'($urandom_range(1, 31)), $urandom);
      step();
    end
    repeat (2) step();

    // x0 write from B completes the handshake but is dropped.
    req_b(5'd0, 32'h0000_1234);
    step();
    step();

    // Same destination from both: A first, then B's data lands last.
    req_a(5'd3, 32'hAAAA_0003);
    req_b(5'd3, 32'hBBBB_0003);
    repeat (3) step();

    // Reset mid-write: outputs clear immediately even with A still presenting.
    req_a(5'd9, 32'hCAFE_F00D);
    step();
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Randomized traffic with mostly-busy A to exercise the starvation guard.
    for (int i = 0; i < 400; i++) begin
      if (!a_pend && $urandom_range(0, 99) < 70) req_a(5'($urandom_range(0, 31)), $urandom);
      if (!b_pend && $urandom_range(0, 99) < 40) req_b(5'($urandom_range(0, 31)), $urandom);
      step();
    end
    a_pend = 1'b0;
    b_pend = 1'b0;
    repeat (2) step();
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
